// File: rtl/branch_pkg.sv
// Shared types and constants for the branch prediction / resolution slice.
// Contents: funct3 encodings, 2-bit direction counter values, BTB entry
// layout, controller state enum and the saturating counter step helper.
package branch_pkg;

    localparam int unsigned XLEN  = 32;
    // Tag slot is sized for the smallest index width; narrower tags are
    // stored zero-extended so the layout does not depend on BTB_IDX_W.
    localparam int unsigned TAG_W = 30;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch-side prediction and EX-side resolution signals of branch_ctrl.
// slave: the controller side; master: the pipeline (or bench) side.
interface branch_ctrl_if;
    import branch_pkg::*;

    logic [XLEN-1:0] if_pc_i;
    logic            if_pred_taken_o;
    logic [XLEN-1:0] if_pred_target_o;

    logic            ex_valid_i;
    logic            ex_is_branch_i;
    logic            ex_is_jump_i;
    logic [2:0]      ex_funct3_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_target_i;
    logic            ex_pred_taken_i;
    logic [XLEN-1:0] ex_pred_target_i;
    logic            br_less_i;
    logic            br_equal_i;
    logic            br_unsigned_o;
    logic            stall_i;

    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_ifid_o;
    logic            flush_idex_o;
    logic [XLEN-1:0] branch_cnt_o;
    logic [XLEN-1:0] mispred_cnt_o;

    modport slave (
        input  if_pc_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_funct3_i,
               ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
               br_less_i, br_equal_i, stall_i,
        output if_pred_taken_o, if_pred_target_o, br_unsigned_o, redirect_o,
               redirect_pc_o, flush_ifid_o, flush_idex_o, branch_cnt_o, mispred_cnt_o
    );

    modport master (
        output if_pc_i, ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_funct3_i,
               ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
               br_less_i, br_equal_i, stall_i,
        input  if_pred_taken_o, if_pred_target_o, br_unsigned_o, redirect_o,
               redirect_pc_o, flush_ifid_o, flush_idex_o, branch_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports: clk_i/rst_ni; lookup (lk_pc_i -> lk_taken_o, lk_target_o, combinational
// from the registered table, no bypass of a same-cycle update); update
// (upd_en_i with pc/target/taken/jump of a resolved control transfer).
module branch_btb
    import branch_pkg::*;
#(
    parameter int unsigned BTB_IDX_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            lk_taken_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            upd_en_i,
    input  logic            upd_taken_i,
    input  logic            upd_jump_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned DEPTH = 1 << BTB_IDX_W;

    btb_entry_t tbl [DEPTH];

    function automatic logic [BTB_IDX_W-1:0] idx_of(input logic [XLEN-1:0] pc);
        return pc[BTB_IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
        return TAG_W'(pc >> (BTB_IDX_W + 2));
    endfunction

    btb_entry_t               lk_e;
    logic                     lk_hit;
    logic [BTB_IDX_W-1:0]     ui;
    logic                     upd_hit;

    // Lookup: predict taken on a hit whose counter is in a taken state.
    assign lk_e        = tbl[idx_of(lk_pc_i)];
    assign lk_hit      = lk_e.valid && (lk_e.tag == tag_of(lk_pc_i));
    assign lk_taken_o  = lk_hit && (lk_e.ctr >= CTR_WT);
    assign lk_target_o = lk_taken_o ? lk_e.target : '0;

    assign ui      = idx_of(upd_pc_i);
    assign upd_hit = tbl[ui].valid && (tbl[ui].tag == tag_of(upd_pc_i));

    // Training: hits adjust the counter, taken misses allocate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (upd_en_i) begin
            if (upd_hit) begin
                tbl[ui].ctr <= upd_jump_i ? CTR_ST : ctr_step(tbl[ui].ctr, upd_taken_i);
                if (upd_taken_i) begin
                    tbl[ui].target <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                tbl[ui] <= '{valid:  1'b1,
                             tag:    tag_of(upd_pc_i),
                             target: upd_target_i,
                             ctr:    upd_jump_i ? CTR_ST : CTR_WT};
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and prediction controller for the 5-stage RV32I pipeline.
// Ports: clk_i, rst_ni (async active-low), bus (branch_ctrl_if.slave) carrying
// the fetch lookup, EX resolution inputs, comparator select, redirect/flush
// outputs and the branch / mispredict performance counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned BTB_IDX_W   = 4,
    parameter int unsigned RECOVER_CYC = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    branch_ctrl_if.slave  bus
);

    localparam int unsigned RCNT_W = $clog2(RECOVER_CYC + 2);

    br_state_e         state;
    logic [RCNT_W-1:0] rcnt;
    logic [XLEN-1:0]   branch_cnt;
    logic [XLEN-1:0]   mispred_cnt;

    logic cond_taken;
    logic f3_legal;
    logic resolve;
    logic actual;
    logic mispredict;

    // Prediction for fetch.
    branch_btb #(.BTB_IDX_W(BTB_IDX_W)) u_btb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lk_pc_i      (bus.if_pc_i),
        .lk_taken_o   (bus.if_pred_taken_o),
        .lk_target_o  (bus.if_pred_target_o),
        .upd_en_i     (resolve),
        .upd_taken_i  (actual),
        .upd_jump_i   (bus.ex_is_jump_i),
        .upd_pc_i     (bus.ex_pc_i),
        .upd_target_i (bus.ex_target_i)
    );

    // funct3[1] separates the unsigned compares (BLTU/BGEU).
    assign bus.br_unsigned_o = bus.ex_funct3_i[1];

    // Condition decode from the comparator results.
    always_comb begin
        cond_taken = 1'b0;
        f3_legal   = 1'b1;
        case (bus.ex_funct3_i)
            BEQ:            cond_taken = bus.br_equal_i;
            BNE:            cond_taken = !bus.br_equal_i;
            BLT, BLTU:      cond_taken = bus.br_less_i;
            BGE, BGEU:      cond_taken = !bus.br_less_i;
            default:        f3_legal   = 1'b0;
        endcase
    end

    assign resolve = bus.ex_valid_i && !bus.stall_i && (state == NORMAL)
                  && (bus.ex_is_jump_i || (bus.ex_is_branch_i && f3_legal));
    assign actual  = bus.ex_is_jump_i || cond_taken;
    assign mispredict = resolve && ((actual != bus.ex_pred_taken_i)
                     || (actual && (bus.ex_pred_target_i != bus.ex_target_i)));

    // Redirect and flushes are held low throughout reset.
    assign bus.redirect_o    = mispredict && rst_ni;
    assign bus.flush_ifid_o  = mispredict && rst_ni;
    assign bus.flush_idex_o  = mispredict && rst_ni;
    assign bus.redirect_pc_o = actual ? bus.ex_target_i : bus.ex_pc_i + XLEN'(4);

    // Wrong-path recovery window: resolutions ignored for RECOVER_CYC unstalled cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= NORMAL;
            rcnt  <= '0;
        end else if (!bus.stall_i) begin
            case (state)
                NORMAL: begin
                    if (mispredict) begin
                        state <= RECOVER;
                        rcnt  <= RCNT_W'(RECOVER_CYC);
                    end
                end
                RECOVER: begin
                    if (rcnt <= RCNT_W'(1)) begin
                        state <= NORMAL;
                        rcnt  <= '0;
                    end else begin
                        rcnt  <= rcnt - RCNT_W'(1);
                    end
                end
                default: begin
                    state <= NORMAL;
                    rcnt  <= '0;
                end
            endcase
        end
    end

    // Performance counters, wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve) begin
                branch_cnt <= branch_cnt + XLEN'(1);
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + XLEN'(1);
            end
        end
    end

    assign bus.branch_cnt_o  = branch_cnt;
    assign bus.mispred_cnt_o = mispred_cnt;

endmodule
